// File: rtl/id_pkg.sv
// Shared decode types for idecode_hz: opcodes, control encodings, ID/EX control record
// and the immediate builder.
package id_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluSlt = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ResAlu = 2'b00,
    ResMem = 2'b01,
    ResPc4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    ImmI = 2'b00,
    ImmS = 2'b01,
    ImmB = 2'b10,
    ImmJ = 2'b11
  } imm_src_e;

  // Register indices are held at full RV32 field width; the top trims them to AW.
  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic        illegal;
    result_src_e result_src;
    alu_ctrl_e   alu_ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } id_ex_t;

  function automatic logic [31:0] imm_build(input logic [31:0] instr, input imm_src_e src);
    logic [31:0] imm;
    unique case (src)
      ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
      ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endcase
    return imm;
  endfunction

  function automatic alu_ctrl_e alu_from_f3(input logic [2:0] f3, input logic sub);
    alu_ctrl_e a;
    case (f3)
      3'b000:  a = sub ? AluSub : AluAdd;
      3'b010:  a = AluSlt;
      3'b110:  a = AluOr;
      3'b111:  a = AluAnd;
      default: a = AluAdd;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file with two combinational read ports and one write port; x0 reads as zero.
// IDECODE_WB_BYPASS_EN makes a same-cycle read of the written register return the new data.
module id_regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  localparam int unsigned AW = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   ra1_i,
  input  logic [AW-1:0]   ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
    rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];
`ifdef IDECODE_WB_BYPASS_EN
    if (we_i && (wa_i != '0) && (wa_i == ra1_i)) rd1_o = wd_i;
    if (we_i && (wa_i != '0) && (wa_i == ra2_i)) rd2_o = wd_i;
`endif
  end

endmodule

// File: rtl/idecode_hz.sv
// RISC-V decode stage: decoder, immediate, load-use stall and the ID/EX register.
// Define IDECODE_WB_BYPASS_EN for write-through register reads.
module idecode_hz import id_pkg::*; #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  localparam int unsigned AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            ValidD,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [AW-1:0]   RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic            StallD,
  output logic            ValidE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic            IllegalE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [AW-1:0]   Rs1E,
  output logic [AW-1:0]   Rs2E,
  output logic [AW-1:0]   RdE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  localparam logic [5:0] NRegLim = 6'(NREG);

  logic [6:0] opcode;
  logic [4:0] rs1_f, rs2_f, rd_f;
  logic       legal_op, uses_rs1, uses_rs2, uses_rd, rs2_hz, illegal_d, load_use;
  imm_src_e   imm_src;
  id_ex_t     dec, e_d, e_q;
  logic [XLEN-1:0] rf_rd1, rf_rd2, imm_d;
  logic [XLEN-1:0] rd1_d, rd2_d, immx_d, pc_d, pcp4_d;
  logic [XLEN-1:0] rd1_q, rd2_q, immx_q, pc_q, pcp4_q;

  assign opcode = InstrD[6:0];
  assign rs1_f  = InstrD[19:15];
  assign rs2_f  = InstrD[24:20];
  assign rd_f   = InstrD[11:7];

  id_regfile #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_regfile (
    .clk_i (clk),
    .rst_i (reset),
    .ra1_i (rs1_f[AW-1:0]),
    .ra2_i (rs2_f[AW-1:0]),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2),
    .we_i  (RegWriteW),
    .wa_i  (RdW),
    .wd_i  (ResultW)
  );

  always_comb begin
    dec      = '0;
    imm_src  = ImmI;
    legal_op = 1'b1;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    uses_rd  = 1'b0;
    case (opcode)
      OpRtype: begin
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = alu_from_f3(InstrD[14:12], InstrD[30]);
        {uses_rs1, uses_rs2, uses_rd} = 3'b111;
      end
      OpItype: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = alu_from_f3(InstrD[14:12], 1'b0);
        {uses_rs1, uses_rd} = 2'b11;
      end
      OpLoad: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = ResMem;
        {uses_rs1, uses_rd} = 2'b11;
      end
      OpStore: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm_src       = ImmS;
        {uses_rs1, uses_rs2} = 2'b11;
      end
      OpBranch: begin
        dec.branch   = 1'b1;
        dec.alu_ctrl = AluSub;
        imm_src      = ImmB;
        {uses_rs1, uses_rs2} = 2'b11;
      end
      OpJal: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = ResPc4;
        imm_src        = ImmJ;
        uses_rd        = 1'b1;
      end
      default: legal_op = 1'b0;
    endcase
    // Register fields beyond the implemented file (RV32E) are illegal only where used.
    illegal_d = ~legal_op
              | (uses_rs1 & ({1'b0, rs1_f} >= NRegLim))
              | (uses_rs2 & ({1'b0, rs2_f} >= NRegLim))
              | (uses_rd  & ({1'b0, rd_f}  >= NRegLim));
    dec.valid = 1'b1;
    dec.rs1   = rs1_f;
    dec.rs2   = rs2_f;
    dec.rd    = rd_f;
    if (illegal_d) begin
      dec.illegal   = 1'b1;
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.jump      = 1'b0;
      dec.branch    = 1'b0;
    end
  end

  assign imm_d = XLEN'($signed(imm_build(InstrD, imm_src)));

  assign rs2_hz   = (opcode == OpRtype) || (opcode == OpStore) || (opcode == OpBranch);
  assign load_use = e_q.valid && (e_q.result_src == ResMem) && (e_q.rd != '0) && ValidD &&
                    ((e_q.rd == rs1_f) || ((e_q.rd == rs2_f) && rs2_hz));
  assign StallD   = load_use && !reset;

  always_comb begin
    e_d    = '0;
    rd1_d  = '0;
    rd2_d  = '0;
    immx_d = '0;
    pc_d   = '0;
    pcp4_d = '0;
    if (!FlushE && !load_use && ValidD) begin
      e_d    = dec;
      rd1_d  = rf_rd1;
      rd2_d  = rf_rd2;
      immx_d = imm_d;
      pc_d   = PCD;
      pcp4_d = PCPlus4D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q    <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      immx_q <= '0;
      pc_q   <= '0;
      pcp4_q <= '0;
    end else begin
      e_q    <= e_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      immx_q <= immx_d;
      pc_q   <= pc_d;
      pcp4_q <= pcp4_d;
    end
  end

  assign ValidE      = e_q.valid;
  assign RegWriteE   = e_q.reg_write;
  assign MemWriteE   = e_q.mem_write;
  assign JumpE       = e_q.jump;
  assign BranchE     = e_q.branch;
  assign ALUSrcE     = e_q.alu_src;
  assign IllegalE    = e_q.illegal;
  assign ResultSrcE  = e_q.result_src;
  assign ALUControlE = e_q.alu_ctrl;
  assign Rs1E        = e_q.rs1[AW-1:0];
  assign Rs2E        = e_q.rs2[AW-1:0];
  assign RdE         = e_q.rd[AW-1:0];
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign ImmExtE     = immx_q;
  assign PCE         = pc_q;
  assign PCPlus4E    = pcp4_q;

endmodule

// File: tb/tb_idecode_hz.sv
// Directed bench for idecode_hz: expected E-stage records are queued as D is driven and
// popped after each clock edge.
module tb_idecode_hz;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        ValidD, FlushE, RegWriteW;
  logic [4:0]  RdW;
  logic        StallD, ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

  always #5 clk = ~clk;

  idecode_hz #(
    .XLEN(32),
    .NREG(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .FlushE     (FlushE),
    .RegWriteW  (RegWriteW),
    .RdW        (RdW),
    .ResultW    (ResultW),
    .StallD     (StallD),
    .ValidE     (ValidE),
    .RegWriteE  (RegWriteE),
    .MemWriteE  (MemWriteE),
    .JumpE      (JumpE),
    .BranchE    (BranchE),
    .ALUSrcE    (ALUSrcE),
    .IllegalE   (IllegalE),
    .ResultSrcE (ResultSrcE),
    .ALUControlE(ALUControlE),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RD1E       (RD1E),
    .RD2E       (RD2E),
    .ImmExtE    (ImmExtE),
    .PCE        (PCE),
    .PCPlus4E   (PCPlus4E)
  );

  // Flags order: valid, reg_write, mem_write, jump, branch, alu_src, illegal.
  typedef struct packed {
    logic [6:0]  flags;
    logic [1:0]  rsrc;
    logic [2:0]  alu;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm, pc, pcp4;
  } exp_t;

  localparam logic [31:0] Add3 = 32'h002081B3;
  localparam logic [31:0] Sub3 = 32'h402081B3;
  localparam logic [31:0] Sw   = 32'h0020A423;
  localparam logic [31:0] Beq  = 32'hFE208EE3;
  localparam logic [31:0] Jal  = 32'h008000EF;
  localparam logic [31:0] Lw   = 32'h0040A283;
  localparam logic [31:0] Add6 = 32'h00128333;
  localparam logic [31:0] Ill  = 32'h0000007F;
  localparam logic [31:0] Add0 = 32'h000001B3;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] pc = 32'h100;
  logic [31:0] byp;
  exp_t        bub = '0;
  exp_t        ill_e;

  function automatic exp_t mk(input logic [6:0] f, input logic [1:0] rs, input logic [2:0] alu,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] imm, input logic [31:0] p);
    return {f, rs, alu, r1, r2, rd, d1, d2, imm, p, p + 32'd4};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic vld, input logic fl, input exp_t e);
    InstrD   = instr;
    ValidD   = vld;
    FlushE   = fl;
    PCD      = pc;
    PCPlus4D = pc + 32'd4;
    sb_q.push_back(e);
  endtask

  task automatic check_bit(input string tag, input logic expv);
    #1;
    total++;
    assert (StallD === expv)
    else begin
      bad++;
      $error("FAIL %s StallD observed=%b expected=%b", tag, StallD, expv);
    end
  endtask

  task automatic tick_cmp(input string tag);
    exp_t o, e;
    @(posedge clk);
    #1;
    o = {ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE, ResultSrcE,
         ALUControlE, Rs1E, Rs2E, RdE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E};
    total++;
    assert (sb_q.size() != 0)
    else begin
      bad++;
      $error("FAIL %s scoreboard empty observed=%h expected=none", tag, o);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      assert (o === e)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef IDECODE_WB_BYPASS_EN
    byp = 32'h55;
`else
    byp = 32'h7;
`endif
    reset = 1'b1; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    drive(Add3, 1'b1, 1'b0, bub);
    check_bit("stall_in_reset", 1'b0);
    tick_cmp("reset0");
    drive(Add3, 1'b1, 1'b0, bub);
    tick_cmp("reset1");

    // Load x1=7, x2=5 through the write-back port with D empty.
    reset = 1'b0; RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'd7;
    drive(Add3, 1'b0, 1'b0, bub);
    tick_cmp("wb_x1");
    RdW = 5'd2; ResultW = 32'd5;
    drive(Add3, 1'b0, 1'b0, bub);
    tick_cmp("wb_x2");
    RegWriteW = 1'b0;

    drive(Add3, 1'b1, 1'b0, mk(7'b1100000, 2'b00, 3'b000, 1, 2, 3, 7, 5, 32'd2, pc));
    tick_cmp("add"); pc += 4;
    drive(Sub3, 1'b1, 1'b0, mk(7'b1100000, 2'b00, 3'b001, 1, 2, 3, 7, 5, 32'h402, pc));
    tick_cmp("sub"); pc += 4;
    drive(Sw, 1'b1, 1'b0, mk(7'b1010010, 2'b00, 3'b000, 1, 2, 8, 7, 5, 32'd8, pc));
    tick_cmp("sw"); pc += 4;
    drive(Beq, 1'b1, 1'b0, mk(7'b1000100, 2'b00, 3'b001, 1, 2, 29, 7, 5, 32'hFFFFFFFC, pc));
    tick_cmp("beq"); pc += 4;
    drive(Jal, 1'b1, 1'b0, mk(7'b1101000, 2'b10, 3'b000, 0, 8, 1, 0, 0, 32'd8, pc));
    tick_cmp("jal"); pc += 4;

    // Load-use: one stall cycle, bubble, then the consumer.
    drive(Lw, 1'b1, 1'b0, mk(7'b1100010, 2'b01, 3'b000, 1, 4, 5, 7, 0, 32'd4, pc));
    tick_cmp("lw"); pc += 4;
    drive(Add6, 1'b1, 1'b0, bub);
    check_bit("stall_lu", 1'b1);
    tick_cmp("lu_bubble");
    drive(Add6, 1'b1, 1'b0, mk(7'b1100000, 2'b00, 3'b000, 5, 1, 6, 0, 7, 32'd1, pc));
    check_bit("stall_released", 1'b0);
    tick_cmp("lu_consumer"); pc += 4;

    drive(Add3, 1'b1, 1'b1, bub);
    tick_cmp("flush");

    drive(Lw, 1'b1, 1'b0, mk(7'b1100010, 2'b01, 3'b000, 1, 4, 5, 7, 0, 32'd4, pc));
    tick_cmp("lw2"); pc += 4;
    drive(Add6, 1'b1, 1'b1, bub);
    check_bit("stall_lu_flush", 1'b1);
    tick_cmp("flush_lu_bubble");
    drive(Add6, 1'b1, 1'b0, mk(7'b1100000, 2'b00, 3'b000, 5, 1, 6, 0, 7, 32'd1, pc));
    tick_cmp("lu_consumer2"); pc += 4;

    ill_e = mk(7'b1000001, 2'b00, 3'b000, 0, 0, 0, 0, 0, 32'd0, pc);
    drive(Ill, 1'b1, 1'b0, ill_e);
    tick_cmp("illegal"); pc += 4;

    // Same-cycle write of x1 while it is read.
    RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h55;
    drive(Add3, 1'b1, 1'b0, mk(7'b1100000, 2'b00, 3'b000, 1, 2, 3, byp, 5, 32'd2, pc));
    tick_cmp("bypass"); pc += 4;
    RegWriteW = 1'b0;
    drive(Add3, 1'b1, 1'b0, mk(7'b1100000, 2'b00, 3'b000, 1, 2, 3, 32'h55, 5, 32'd2, pc));
    tick_cmp("after_wb"); pc += 4;

    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hDEAD;
    drive(Add0, 1'b1, 1'b0, mk(7'b1100000, 2'b00, 3'b000, 0, 0, 3, 0, 0, 32'd0, pc));
    tick_cmp("x0_same"); pc += 4;
    RegWriteW = 1'b0;
    drive(Add0, 1'b1, 1'b0, mk(7'b1100000, 2'b00, 3'b000, 0, 0, 3, 0, 0, 32'd0, pc));
    tick_cmp("x0_after"); pc += 4;

    // Reset during a stall abandons it and clears the register file.
    drive(Lw, 1'b1, 1'b0, mk(7'b1100010, 2'b01, 3'b000, 1, 4, 5, 32'h55, 0, 32'd4, pc));
    tick_cmp("lw3"); pc += 4;
    drive(Add6, 1'b1, 1'b0, bub);
    check_bit("stall_pre_reset", 1'b1);
    reset = 1'b1;
    check_bit("stall_reset", 1'b0);
    tick_cmp("reset_mid_stall");
    reset = 1'b0;
    drive(Add3, 1'b1, 1'b0, mk(7'b1100000, 2'b00, 3'b000, 1, 2, 3, 0, 0, 32'd2, pc));
    check_bit("stall_after_reset", 1'b0);
    tick_cmp("rf_cleared");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idecode_hz.md
# idecode_hz

Parametrised RISC-V instruction-decode stage with integrated hazard handling, sitting between the IF/ID register and the execute stage. It decodes `InstrD`, reads the register file with an optional write-back bypass, and builds the immediate. It detects load-use hazards, requesting an upstream stall and inserting a bubble when one occurs. It owns the ID/EX pipeline register, including valid, flush and illegal-instruction tracking.

## Interface
- `XLEN`, 32: datapath width (register, PC and immediate width).
- `NREG`, 32: architectural register count (32, or 16 for RV32E); `AW = $clog2(NREG)`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `InstrD` in 32: instruction from the IF/ID register.
- `PCD`, `PCPlus4D` in XLEN: PC and PC+4 of the instruction in D.
- `ValidD` in 1: D holds a real instruction.
- `FlushE` in 1: taken branch/jump resolved in EX; bubble E next cycle.
- `RegWriteW` in 1, `RdW` in AW, `ResultW` in XLEN: write-back port.
- `StallD` out 1: combinational; freeze PC and IF/ID this cycle.
- `ValidE`, `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ALUSrcE`, `IllegalE` out 1 each.
- `ResultSrcE` out 2; `ALUControlE` out 3.
- `Rs1E`, `Rs2E`, `RdE` out AW: register indices for the forwarding unit.
- `RD1E`, `RD2E`, `ImmExtE`, `PCE`, `PCPlus4E` out XLEN.

## Operation
- Decoded opcodes are lw `0000011`, sw `0100011`, R-type `0110011`, I-ALU `0010011`, beq `1100011` and jal `1101111`.
  - Any other opcode sets IllegalD.
  - Any register field ≥ NREG also sets IllegalD.
- ALUControl encoding: 000 add, 001 sub (R-type funct3=000 with `InstrD[30]`=1), 010 and, 011 or, 101 slt. beq uses sub.
- ResultSrc encoding: 00 ALU, 01 memory, 10 PC+4.
- ImmSrc encoding: 00 I, 01 S, 10 B, 11 J. The immediate is sign-extended to XLEN.
- Register file:
  - x0 reads as 0.
  - A write occurs on a clk edge when `RegWriteW` is high and `RdW`≠0.
  - `reset` clears all registers.
- Load-use hazard: `ValidE` & `ResultSrcE`==01 & `RdE`≠0 & (`RdE`==rs1D or (`RdE`==rs2D and D is R-type, sw or beq)) & `ValidD`.
  - Effect: `StallD`=1 and the E register loads a bubble.
- Bubble: every E output is 0, including `ValidE`, `IllegalE` and the data fields.
- E register next-state priority: `reset` > `FlushE` > load-use > normal load.
- Normal load:
  - ValidD=0: E loads a bubble.
  - IllegalD=1: `ValidE`=1 and `IllegalE`=1, with all write/jump/branch controls 0.
- `FlushE` together with load-use: E loads a bubble, and `StallD` still asserts in that cycle.

## Timing
- Latency: D inputs appear on the E outputs one clk edge later.
- Reset: all E outputs are 0 on the edge where `reset` is sampled high. `StallD` is 0 while `reset` is high.
- `StallD` depends only on E-register state and `InstrD`/`ValidD`, so it has no path from the W inputs.
- A stall lasts exactly one cycle per load-use pair, because the bubble clears `ValidE`.
- Reset asserted mid-stall: the stall is abandoned and the next cycle starts from an empty E.

## Configuration
- `IDECODE_WB_BYPASS_EN` defined: a read of register r in the same cycle that W writes r (r≠0) returns `ResultW`, i.e. write-through.
- Not defined: that read returns the pre-write value. The forwarding unit must then cover the W→D distance.

## Structure
- Package `id_pkg` holds:
  - opcode localparams;
  - `alu_ctrl_e`, `result_src_e` and `imm_src_e` enums;
  - the packed `id_ex_t` struct for the E register.
- Sub-module `id_regfile` is parametrised by XLEN and NREG and contains the bypass macro logic.
- Decoder, immediate extender and hazard detection stay inline in `idecode_hz`.

## Test plan
- Reset: hold `reset` for 2 cycles with `ValidD`=1 → all E outputs 0 and `StallD`=0.
- Decode, x1=7 and x2=5:
  - `InstrD`=0x002081B3 (add x3,x1,x2) → next cycle RD1E=7, RD2E=5, RdE=3, RegWriteE=1, ALUControlE=000, ResultSrcE=00.
  - Same encoding with bit 30 set → ALUControlE=001.
- Load-use:
  - 0x0040A283 (lw x5,4(x1)) followed by 0x00128333 (add x6,x5,x1) → StallD=1 for one cycle, then a bubble in E (ValidE=0).
  - The add then enters E with Rs1E=5; ImmExtE for the lw was 4.
- Flush: FlushE=1 while D holds a valid add → next-cycle ValidE=0 and RegWriteE=0. FlushE asserted during a load-use stall also yields a bubble.
- Illegal: `InstrD`=0x0000007F → ValidE=1, IllegalE=1, RegWriteE=0, MemWriteE=0.
- Bypass: RegWriteW=1, RdW=1, ResultW=0x55 in the same cycle that add x3,x1,x2 is decoded (x1 previously 7):
  - with the macro → RD1E=0x55;
  - without the macro → RD1E=7.
  - RdW=0 never changes x0.
